// File: rtl/glove_tracker.sv
// glove_tracker: colour-threshold pixel classifier with per-frame centroid.
// Matching pixels are counted and their coordinates summed over a frame. At
// frame end (vsync falling) the sums are divided by the count with a
// sequential restoring divider, and the centroid is published with a strobe.
module glove_tracker #(
    parameter logic [7:0]  R_MIN        = 8'hC0,
    parameter logic [7:0]  G_MAX        = 8'h40,
    parameter logic [7:0]  B_MAX        = 8'h40,
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned MIN_COUNT    = 16,
    parameter int unsigned CLOSED_COUNT = 64
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        vsync,
    input  logic        pixel_valid,
    input  logic [23:0] pixel_in,
    output logic [10:0] glove_x,
    output logic [9:0]  glove_y,
    output logic [19:0] glove_count,
    output logic        glove_found,
    output logic        glove_closed,
    output logic        coord_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        StAccum,
        StDivX,
        StDivY
    } state_t;

    state_t      state_q;
    logic        vsync_d;
    logic        frame_end;
    logic        match;
    logic [19:0] cnt_q;
    logic [29:0] sum_x_q;
    logic [29:0] sum_y_q;

    // Divider datapath: quot_q starts as the dividend and shifts left, taking
    // one quotient bit in at the LSB per cycle.
    logic [19:0] div_q;
    logic [29:0] sum_y_snap_q;
    logic [29:0] quot_q;
    logic [19:0] rem_q;
    logic [4:0]  iter_q;
    logic [10:0] quot_x_q;

    logic [20:0] rem_shift;
    logic        q_bit;
    logic [19:0] rem_next;
    logic [29:0] quot_next;

    // Pixel classification and frame-end detection.
    always_comb begin
        frame_end = vsync_d & ~vsync;
        match = pixel_valid
              && (32'(hcount) < H_ACTIVE)
              && (32'(vcount) < V_ACTIVE)
              && (pixel_in[23:16] >= R_MIN)
              && (pixel_in[15:8] <= G_MAX)
              && (pixel_in[7:0] <= B_MAX);
    end

    // One restoring-divide step; remainder stays below the 20-bit divisor.
    always_comb begin
        rem_shift = {rem_q, quot_q[29]};
        q_bit     = (rem_shift >= {1'b0, div_q});
        rem_next  = q_bit ? 20'(rem_shift - {1'b0, div_q}) : rem_shift[19:0];
        quot_next = {quot_q[28:0], q_bit};
    end

    // Frame accumulators; cleared at frame end so that cycle's pixel is dropped.
    always_ff @(posedge vclock) begin
        if (reset) begin
            vsync_d <= 1'b1;
            cnt_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else begin
            vsync_d <= vsync;
            if (frame_end) begin
                cnt_q   <= '0;
                sum_x_q <= '0;
                sum_y_q <= '0;
            end else if (match) begin
                cnt_q   <= cnt_q + 20'd1;
                sum_x_q <= sum_x_q + 30'(hcount);
                sum_y_q <= sum_y_q + 30'(vcount);
            end
        end
    end

    // Control FSM: snapshot at frame end, divide x then y, publish outputs.
    always_ff @(posedge vclock) begin
        if (reset) begin
            state_q      <= StAccum;
            div_q        <= '0;
            sum_y_snap_q <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            iter_q       <= '0;
            quot_x_q     <= '0;
            glove_x      <= '0;
            glove_y      <= '0;
            glove_count  <= '0;
            glove_found  <= 1'b0;
            glove_closed <= 1'b0;
            coord_valid  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coord_valid <= 1'b0;
            unique case (state_q)
                StAccum: begin
                    if (frame_end) begin
                        div_q        <= cnt_q;
                        sum_y_snap_q <= sum_y_q;
                        if (32'(cnt_q) < MIN_COUNT) begin
                            // Too few pixels: report immediately, keep old centroid.
                            glove_count  <= cnt_q;
                            glove_found  <= 1'b0;
                            glove_closed <= 1'b0;
                            coord_valid  <= 1'b1;
                        end else begin
                            quot_q  <= sum_x_q;
                            rem_q   <= '0;
                            iter_q  <= '0;
                            busy    <= 1'b1;
                            state_q <= StDivX;
                        end
                    end
                end
                StDivX: begin
                    quot_q <= quot_next;
                    rem_q  <= rem_next;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'd29) begin
                        quot_x_q <= quot_next[10:0];
                        quot_q   <= sum_y_snap_q;
                        rem_q    <= '0;
                        iter_q   <= '0;
                        state_q  <= StDivY;
                    end
                end
                StDivY: begin
                    quot_q <= quot_next;
                    rem_q  <= rem_next;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'd29) begin
                        // Final y bit is taken straight from the step logic.
                        glove_x      <= quot_x_q;
                        glove_y      <= quot_next[9:0];
                        glove_count  <= div_q;
                        glove_found  <= 1'b1;
                        glove_closed <= (32'(div_q) < CLOSED_COUNT);
                        coord_valid  <= 1'b1;
                        busy         <= 1'b0;
                        iter_q       <= '0;
                        state_q      <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

endmodule

// File: tb/tb_glove_tracker.sv
// Testbench for glove_tracker: directed and randomized frames, reference model
// from the matching rules, scoreboard queue popped by a monitor on coord_valid.
module tb_glove_tracker;

    logic        vclock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        vsync = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [23:0] pixel_in = '0;
    logic [10:0] glove_x;
    logic [9:0]  glove_y;
    logic [19:0] glove_count;
    logic        glove_found;
    logic        glove_closed;
    logic        coord_valid;
    logic        busy;

    glove_tracker dut (
        .vclock      (vclock),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .vsync       (vsync),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .glove_x     (glove_x),
        .glove_y     (glove_y),
        .glove_count (glove_count),
        .glove_found (glove_found),
        .glove_closed(glove_closed),
        .coord_valid (coord_valid),
        .busy        (busy)
    );

    always #5 vclock = ~vclock;

    int cyc = 0;
    always @(posedge vclock) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [10:0] x;
        logic [9:0]  y;
        logic [19:0] cnt;
        logic        found;
        logic        closed;
    } exp_t;

    exp_t        sb[$];
    longint      m_cnt = 0;
    longint      m_sx = 0;
    longint      m_sy = 0;
    logic [10:0] last_x = '0;
    logic [9:0]  last_y = '0;
    int          busy_from = 0;
    int          busy_to = 0;
    bit          mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic bit is_match(input int h, input int v, input bit val,
                                    input logic [23:0] p);
        return val && (h < 1024) && (v < 768) && (p[23:16] >= 8'hC0)
            && (p[15:8] <= 8'h40) && (p[7:0] <= 8'h40);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vclock);
            #1;
            vsync = 1'b1;
            pixel_valid = 1'b0;
        end
    endtask

    task automatic drive_px(input int h, input int v, input bit val, input logic [23:0] p);
        @(posedge vclock);
        #1;
        vsync = 1'b1;
        hcount = 11'(h);
        vcount = 10'(v);
        pixel_valid = val;
        pixel_in = p;
        if (is_match(h, v, val, p)) begin
            m_cnt++;
            m_sx += h;
            m_sy += v;
        end
    endtask

    task automatic drive_block(input int x0, input int y0, input int w, input int h,
                               input logic [23:0] p);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                drive_px(x0 + i, y0 + j, 1'b1, p);
    endtask

    // Drives the vsync falling edge; the pixel in that cycle must be ignored.
    task automatic end_frame(input bit junk);
        exp_t e;
        int   fe;
        @(posedge vclock);
        #1;
        vsync = 1'b0;
        hcount = 11'd105;
        vcount = 10'd205;
        pixel_valid = junk;
        pixel_in = 24'hFF2020;
        fe = cyc + 1;
        if (fe > busy_to) begin
            e.cnt = 20'(m_cnt);
            if (m_cnt >= 16) begin
                e.found = 1'b1;
                e.closed = (m_cnt < 64);
                e.x = 11'(m_sx / m_cnt);
                e.y = 10'(m_sy / m_cnt);
                e.at = fe + 60;
                last_x = e.x;
                last_y = e.y;
                busy_from = fe;
                busy_to = fe + 60;
            end else begin
                e.found = 1'b0;
                e.closed = 1'b0;
                e.x = last_x;
                e.y = last_y;
                e.at = fe;
            end
            sb.push_back(e);
        end
        m_cnt = 0;
        m_sx = 0;
        m_sy = 0;
    endtask

    task automatic do_reset();
        int r;
        @(posedge vclock);
        #1;
        reset = 1'b1;
        pixel_valid = 1'b0;
        vsync = 1'b1;
        r = cyc + 1;
        sb.delete();
        if (busy_to > r) busy_to = r;
        m_cnt = 0;
        m_sx = 0;
        m_sy = 0;
        last_x = '0;
        last_y = '0;
        @(posedge vclock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge vclock);
        check({tag, "_x"}, glove_x, 0);
        check({tag, "_y"}, glove_y, 0);
        check({tag, "_count"}, glove_count, 0);
        check({tag, "_found"}, glove_found, 0);
        check({tag, "_closed"}, glove_closed, 0);
        check({tag, "_valid"}, coord_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        int s = $urandom_range(0, 4);
        if (s == 0) return a;
        if (s == 1) return b;
        if (s == 2) return c;
        if (s == 3) return 8'(b);
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge vclock);
            if (mon_en) begin
                check("busy", busy, (cyc >= busy_from && cyc < busy_to));
                if (coord_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_coord_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("valid_cycle", cyc, e.at);
                        check("glove_x", glove_x, e.x);
                        check("glove_y", glove_y, e.y);
                        check("glove_count", glove_count, e.cnt);
                        check("glove_found", glove_found, e.found);
                        check("glove_closed", glove_closed, e.closed);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        idle(3);
        #1;
        reset = 1'b0;
        check_zero("reset");
        mon_en = 1'b1;

        // 10x10 block centred at (104,204) with ignored pixels around it.
        drive_block(100, 200, 10, 10, 24'hFF1010);
        for (int i = 0; i < 6; i++) drive_px(1024 + 100 * i, 205, 1'b1, 24'hFF0000);
        for (int i = 0; i < 6; i++) drive_px(104, 770 + i, 1'b1, 24'hFF0000);
        for (int i = 0; i < 6; i++) drive_px(104, 204, 1'b0, 24'hFF0000);
        end_frame(1'b1);
        idle(65);

        // Empty frame: not found, centroid held.
        end_frame(1'b0);
        idle(5);

        // Threshold edges.
        drive_block(100, 200, 10, 10, 24'hBF1010);
        end_frame(1'b0);
        idle(5);
        drive_block(100, 200, 10, 10, 24'hFF4110);
        end_frame(1'b0);
        idle(5);
        drive_block(100, 200, 10, 10, 24'hC04040);
        end_frame(1'b0);
        idle(65);

        // Closed glove.
        drive_block(300, 50, 7, 7, 24'hE03000);
        end_frame(1'b0);
        idle(65);

        // Second frame end while busy is dropped; next frame tracked.
        drive_block(500, 600, 5, 5, 24'hFF0000);
        end_frame(1'b0);
        idle(19);
        end_frame(1'b0);
        idle(45);
        drive_block(20, 30, 4, 6, 24'hFF0000);
        end_frame(1'b0);
        idle(65);

        // Reset during the x divide.
        drive_block(400, 400, 9, 9, 24'hFF0000);
        end_frame(1'b0);
        idle(14);
        do_reset();
        check_zero("midreset");
        drive_block(700, 100, 8, 3, 24'hF00000);
        end_frame(1'b0);
        idle(65);

        // Randomized frames, gaps sometimes short enough to overlap a divide.
        for (int f = 0; f < 24; f++) begin
            int w  = $urandom_range(1, 12);
            int h  = $urandom_range(1, 12);
            int x0 = $urandom_range(0, 1030);
            int y0 = $urandom_range(0, 775);
            for (int j = 0; j < h; j++)
                for (int i = 0; i < w; i++)
                    drive_px(x0 + i, y0 + j, ($urandom_range(0, 7) != 0),
                             {pick(8'hC0, 8'hFF, 8'hBF), pick(8'h40, 8'h00, 8'h41),
                              pick(8'h40, 8'h10, 8'h41)});
            end_frame(1'(($urandom_range(0, 1))));
            idle($urandom_range(0, 80));
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        idle(3);
        check("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
